seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
- Programmable controller and sequencer for the serial sequence-detector datapath.
- Latches a pattern and mode configuration, arms detection on `start`, and samples serial input `x` once per cycle.
- Emits a registered, Moore-style one-cycle `match` pulse and counts matches.
- Finishes after a programmable target count. Replaces the fixed-pattern "101" detectors with one configurable block under software/FSM control.

Parameters:
- MAXLEN, 8, maximum pattern length in bits.
- CNTW, 8, width of the match counter and the target field.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, latch config and begin a run; honoured in IDLE and DONE only.
- abort, input, 1, terminate the run and return to IDLE.
- cfg_pattern, input, MAXLEN, pattern; bit [cfg_len-1] is the first bit received, bit [0] the last.
- cfg_len, input, 4, pattern length; legal range 1..MAXLEN.
- cfg_overlap, input, 1, 1 = overlapping detection, 0 = non-overlapping.
- cfg_target, input, CNTW, match count that ends the run; 0 = run until abort.
- x, input, 1, serial data bit.
- busy, output, 1, high in ARM and RUN.
- match, output, 1, one-cycle pulse per detected pattern.
- match_count, output, CNTW, matches in the current or last run.
- done, output, 1, high while in DONE.
- err, output, 1, one-cycle pulse when start is rejected because of an illegal cfg_len.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, history and count cleared. Outputs: busy=0, match=0, match_count=0, done=0, err=0.
- States: IDLE, ARM, RUN, DONE. The state register is 2 bits; all outputs are registered.
- IDLE:
  - start with cfg_len in 1..MAXLEN: latch all cfg_* fields, clear match_count, go to ARM.
  - start with cfg_len = 0 or cfg_len > MAXLEN: err=1 for the next cycle, stay in IDLE, nothing latched.
- ARM (exactly 1 cycle): clear the history shift register and the valid-bit count hv; go to RUN. x is not sampled in ARM.
- RUN, per rising edge:
  - Shift x into the history register (depth MAXLEN) and set hv = min(hv+1, MAXLEN).
  - A hit occurs when hv_after >= len and the low len bits of the history equal the low len bits of the pattern.
  - On a hit, on the same edge: match<=1 and match_count<=match_count+1, saturating at 2^CNTW-1.
  - Non-overlap mode: a hit also sets hv<=0, so the bits of the hit are not reused.
  - Overlap mode: a hit leaves hv unchanged.
  - If cfg_target != 0 and the new count equals cfg_target, go to DONE on that same edge.
  - Result: match and done rise together. Match latency is 1 cycle after the edge that samples the final pattern bit.
- match is high for exactly one cycle per hit. Back-to-back hits are possible in overlap mode (e.g. pattern 11, stream 111).
- DONE: done=1 and busy=0; history is frozen and x is ignored.
  - start (legal cfg_len) begins a new run through ARM and clears match_count.
  - start with an illegal cfg_len pulses err and goes to IDLE.
  - abort goes to IDLE.
- abort: in ARM, RUN or DONE, go to IDLE on the next edge; match_count is retained and match is forced to 0. abort has priority over a simultaneous hit: the count is not incremented.
- start while busy is ignored. cfg_* changes during a run have no effect.
- start and abort asserted together in IDLE: abort wins, no run starts.
- Reset mid-run returns all state to the reset values immediately (asynchronous).

Test Plan:
- Non-overlap, cfg_pattern=101, len=3, target=0; x=1,0,1,0,1 on successive RUN cycles → one match pulse, 1 cycle after the 3rd bit; match_count=1; busy stays high.
- Same stream with overlap=1 → two match pulses, 2 cycles apart (after bits 3 and 5); match_count=2.
- Overlap, pattern=11, len=2, target=3; x=1,1,1,1 → match high for 3 consecutive cycles; done rises with the 3rd match; busy=0; further x ignored; match_count=3.
- start with cfg_len=0, then cfg_len=9 → err pulses 1 cycle each time; state stays IDLE; busy=0.
- abort on the same edge that samples the final bit of a hit → no match, match_count unchanged, IDLE next cycle; a later start clears the count to 0.
- rst=0 mid-RUN with match_count=2 → all outputs 0 without waiting for a clock edge; after release the block sits in IDLE until start.
- CNTW=2, target=0, overlap, pattern=1, len=1, x held at 1 for 5 cycles → match_count reads 1,2,3,3,3 (saturates).

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
//   Programmable serial sequence detector with run control. A legal start
//   latches the pattern, length, overlap and target fields. The block then
//   spends one cycle in ARM clearing its history and moves to RUN. In RUN it
//   shifts x into a history register once per cycle, pulses match on each
//   hit, and counts hits with saturation. When a non-zero target count is
//   reached it stops in DONE. All outputs are registered.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   start, abort       run control (start honoured in IDLE/DONE only)
//   cfg_pattern        pattern; bit [cfg_len-1] is received first
//   cfg_len            pattern length, legal 1..MAXLEN
//   cfg_overlap        1 = hits may share bits
//   cfg_target         match count that ends the run, 0 = run until abort
//   x                  serial input bit
//   busy, done         high in ARM/RUN, high in DONE
//   match              one-cycle pulse per hit
//   match_count        saturating hit count of the current/last run
//   err                one-cycle pulse on start with an illegal cfg_len
module seq_detect_ctrl #(
  parameter int MAXLEN = 8,
  parameter int CNTW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [3:0]        cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNTW-1:0]   cfg_target,
  input  logic              x,
  output logic              busy,
  output logic              match,
  output logic [CNTW-1:0]   match_count,
  output logic              done,
  output logic              err
);

  localparam int HVW = $clog2(MAXLEN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [MAXLEN-1:0] pat_q, pat_d, hist_q, hist_d, hist_sh, lmask;
  logic [3:0]        len_q, len_d;
  logic              ovl_q, ovl_d;
  logic [CNTW-1:0]   tgt_q, tgt_d, cnt_d, cnt_inc;
  logic [HVW-1:0]    hv_q, hv_d, hv_inc;
  logic              match_d, err_d, busy_d, done_d;
  logic              cfg_ok, hit;

  // Compare mask: only the low len bits of history/pattern take part.
  for (genvar i = 0; i < MAXLEN; i++) begin : g_mask
    assign lmask[i] = (i < int'(len_q));
  end

  assign cfg_ok  = (cfg_len != 4'd0) && (int'(cfg_len) <= MAXLEN);
  // Newest bit enters at bit 0, so the first pattern bit ends up at len-1.
  assign hist_sh = MAXLEN'({hist_q, x});
  assign hv_inc  = (hv_q == HVW'(MAXLEN)) ? hv_q : hv_q + HVW'(1);
  assign cnt_inc = (&match_count) ? match_count : match_count + CNTW'(1);
  assign hit     = (int'(hv_inc) >= int'(len_q)) &&
                   (((hist_sh ^ pat_q) & lmask) == '0);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    tgt_d   = tgt_q;
    hist_d  = hist_q;
    hv_d    = hv_q;
    cnt_d   = match_count;
    match_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          if (cfg_ok) begin
            pat_d   = cfg_pattern;
            len_d   = cfg_len;
            ovl_d   = cfg_overlap;
            tgt_d   = cfg_target;
            cnt_d   = '0;
            state_d = ARM;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      ARM: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          hist_d  = '0;
          hv_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // abort wins over a hit on the same edge: no pulse, no count.
        if (abort) begin
          state_d = IDLE;
        end else begin
          hist_d = hist_sh;
          hv_d   = hv_inc;
          if (hit) begin
            match_d = 1'b1;
            cnt_d   = cnt_inc;
            if (!ovl_q) hv_d = '0;
            if (tgt_q != '0 && cnt_inc == tgt_q) state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ARM) || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      tgt_q       <= '0;
      hist_q      <= '0;
      hv_q        <= '0;
      match_count <= '0;
      match       <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      ovl_q       <= ovl_d;
      tgt_q       <= tgt_d;
      hist_q      <= hist_d;
      hv_q        <= hv_d;
      match_count <= cnt_d;
      match       <= match_d;
      err         <= err_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;
  localparam int MAXLEN = 8;
  localparam int CNTW   = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              start = 0, abort = 0, cfg_overlap = 0, x = 0;
  logic [MAXLEN-1:0] cfg_pattern = '0;
  logic [3:0]        cfg_len = '0;
  logic [CNTW-1:0]   cfg_target = '0;
  logic              busy, match, done, err;
  logic [CNTW-1:0]   match_count;

  seq_detect_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_target(cfg_target), .x(x), .busy(busy), .match(match),
    .match_count(match_count), .done(done), .err(err));

  // Narrow-counter instance for the saturation case.
  logic              s_start = 0, s_abort = 0, s_ovl = 0, s_x = 0;
  logic [MAXLEN-1:0] s_pat = '0;
  logic [3:0]        s_len = '0;
  logic [1:0]        s_tgt = '0;
  logic              s_busy, s_match, s_done, s_err;
  logic [1:0]        s_cnt;

  seq_detect_ctrl #(.MAXLEN(MAXLEN), .CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
    .cfg_pattern(s_pat), .cfg_len(s_len), .cfg_overlap(s_ovl),
    .cfg_target(s_tgt), .x(s_x), .busy(s_busy), .match(s_match),
    .match_count(s_cnt), .done(s_done), .err(s_err));

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int at; int cnt; bit dn; } exp_t;
  exp_t sbq[$];
  exp_t e;

  task automatic chk(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every match pulse must line up with the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      while (sbq.size() > 0 && sbq[0].at < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL missed_match: got no pulse, expected pulse at cycle %0d", sbq[0].at);
        void'(sbq.pop_front());
      end
      if (match) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_match: got pulse at cycle %0d, expected none", cyc);
        end else begin
          e = sbq.pop_front();
          chk("match_cycle", cyc, e.at);
          chk("match_count_at_pulse", int'(match_count), e.cnt);
          chk("done_at_pulse", int'(done), int'(e.dn));
        end
      end
    end
  end

  // Reference model: the last len received bits of the current run.
  int       m_len, m_tgt, m_cnt;
  bit [7:0] m_pat;
  bit       m_ovl, m_active, m_done;
  bit       hb[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(int len, bit [7:0] pat, bit ovl, int tgt);
    cfg_len = 4'(len); cfg_pattern = pat; cfg_overlap = ovl; cfg_target = CNTW'(tgt);
    start = 1; tick; start = 0;
    // config must already be latched; scramble it during ARM
    cfg_pattern = MAXLEN'($urandom); cfg_len = 4'($urandom);
    cfg_overlap = 1'($urandom); cfg_target = CNTW'($urandom);
    x = 1'($urandom); tick;
    m_len = len; m_pat = pat; m_ovl = ovl; m_tgt = tgt;
    m_active = 1; m_done = 0; m_cnt = 0; hb.delete();
  endtask

  task automatic send(bit b);
    bit hit;
    x = b;
    if (m_active && !m_done) begin
      hb.push_back(b);
      if (hb.size() > m_len) void'(hb.pop_front());
      if (hb.size() == m_len) begin
        hit = 1;
        for (int i = 0; i < m_len; i++) if (hb[i] != m_pat[m_len-1-i]) hit = 0;
        if (hit) begin
          if (m_cnt < (1 << CNTW) - 1) m_cnt++;
          if (!m_ovl) hb.delete();
          if (m_tgt != 0 && m_cnt == m_tgt) m_done = 1;
          sbq.push_back('{cyc + 1, m_cnt, m_done});
        end
      end
    end
    tick;
  endtask

  task automatic do_abort(bit b);
    x = b; abort = 1; tick; abort = 0;
    m_active = 0;
  endtask

  task automatic status(string tag, int eb, int ed, int ec);
    @(negedge clk);
    chk({tag, "_busy"}, int'(busy), eb);
    chk({tag, "_done"}, int'(done), ed);
    chk({tag, "_count"}, int'(match_count), ec);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_match", int'(match), 0);
    chk("rst_count", int'(match_count), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk); rst = 1;
    tick;

    // non-overlap 101 on 1,0,1,0,1: one hit
    do_start(3, 8'b101, 0, 0);
    foreach (hb[i]) ;
    send(1); send(0); send(1); send(0); send(1);
    status("nonovl", 1, 0, 1);
    do_abort(0);

    // overlap: two hits, two cycles apart
    do_start(3, 8'b101, 1, 0);
    send(1); send(0); send(1); send(0); send(1);
    status("ovl", 1, 0, 2);
    do_abort(0);

    // pattern 11, target 3: back-to-back hits, done with the third
    do_start(2, 8'b11, 1, 3);
    send(1); send(1); send(1); send(1); send(1);
    status("tgt", 0, 1, 3);

    // illegal start from DONE: err pulse, back to IDLE
    cfg_len = 4'd0; start = 1; tick; start = 0; m_active = 0;
    @(negedge clk);
    chk("err_len0", int'(err), 1);
    chk("err_len0_busy", int'(busy), 0);
    chk("err_len0_done", int'(done), 0);
    tick;
    chk("err_clear", int'(err), 0);
    cfg_len = 4'd9; start = 1; tick; start = 0;
    @(negedge clk);
    chk("err_len9", int'(err), 1);
    chk("err_len9_busy", int'(busy), 0);
    tick;
    chk("err_len9_clear", int'(err), 0);
    // start and abort together in IDLE: nothing starts
    cfg_len = 4'd3; start = 1; abort = 1; tick; start = 0; abort = 0;
    @(negedge clk);
    chk("start_abort_busy", int'(busy), 0);

    // abort on the edge that samples the last bit of a hit
    tick;
    do_start(3, 8'b101, 0, 0);
    send(1); send(0); send(1);
    send(1); send(0);
    do_abort(1);
    status("abort_hit", 0, 0, 1);
    tick;
    status("abort_idle", 0, 0, 1);
    do_start(3, 8'b101, 0, 0);
    status("restart_clear", 1, 0, 0);

    // asynchronous reset mid-run with count 2
    send(1); send(0); send(1); send(1); send(0); send(1);
    status("pre_rst", 1, 0, 2);
    #1 rst = 0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_count", int'(match_count), 0);
    chk("async_rst_match", int'(match), 0);
    chk("async_rst_done", int'(done), 0);
    m_active = 0;
    #1 rst = 1;
    tick; tick; tick;
    status("post_rst", 0, 0, 0);

    // 2-bit counter saturation
    s_pat = 8'b1; s_len = 4'd1; s_ovl = 1; s_tgt = 2'd0; s_x = 1;
    s_start = 1; tick; s_start = 0; tick;
    for (int i = 0; i < 5; i++) begin
      tick;
      @(negedge clk);
      chk("sat_count", int'(s_cnt), (i + 1 < 3) ? i + 1 : 3);
      chk("sat_match", int'(s_match), 1);
    end
    s_abort = 1; tick; s_abort = 0;

    // randomized runs
    for (int r = 0; r < 40; r++) begin
      int len, tgt, nb;
      bit [7:0] pat;
      bit ovl, b;
      len = $urandom_range(1, MAXLEN);
      pat = 8'($urandom) & 8'((1 << len) - 1);
      ovl = 1'($urandom);
      tgt = $urandom_range(0, 5);
      do_start(len, pat, ovl, tgt);
      nb = $urandom_range(8, 40);
      for (int j = 0; j < nb; j++) begin
        if ($urandom_range(0, 3) == 0) b = 1'($urandom);
        else b = pat[len - 1 - (j % len)];
        if (!m_done && $urandom_range(0, 15) == 0) begin
          cfg_len = 4'($urandom); start = 1;
        end
        send(b);
        start = 0;
      end
      status("rnd", m_done ? 0 : 1, m_done ? 1 : 0, m_cnt);
      if (!(m_done && $urandom_range(0, 1) == 1)) begin
        do_abort(1'($urandom));
        status("rnd_abort", 0, 0, m_cnt);
      end
    end

    do_abort(0);
    tick; tick; tick;
    chk("scoreboard_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
